// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between pong_match_ctrl and the detection / motion / display blocks.
// pause/paused exist only when PONG_MATCH_PAUSE_EN is defined.
interface pong_match_ctrl_if;
  logic       tick;
  logic       start;
  logic       goal_left;
  logic       goal_right;
  logic       paddle_hit;
  logic       ball_run;
  logic       ball_reset;
  logic       serve_dir;
  logic [6:0] speed;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [2:0] phase;
  logic       winner;
  logic       game_over;
`ifdef PONG_MATCH_PAUSE_EN
  logic       pause;
  logic       paused;
`endif

  modport slave (
    input  tick, start, goal_left, goal_right, paddle_hit,
    output ball_run, ball_reset, serve_dir, speed, p1_score, p2_score,
           phase, winner, game_over
`ifdef PONG_MATCH_PAUSE_EN
    , input pause, output paused
`endif
  );

  modport master (
    output tick, start, goal_left, goal_right, paddle_hit,
    input  ball_run, ball_reset, serve_dir, speed, p1_score, p2_score,
           phase, winner, game_over
`ifdef PONG_MATCH_PAUSE_EN
    , output pause, input paused
`endif
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for pong: serve timing, speed, scores, match end.
// Optional pause support is enabled by defining PONG_MATCH_PAUSE_EN.
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 60,
  parameter int INIT_SPEED  = 2,
  parameter int MAX_SPEED   = 15
) (
  input logic              clk,
  input logic              rst_n,
  pong_match_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } phase_e;

  phase_e     phase_q;
  logic [7:0] cnt_q;
  logic [6:0] speed_q;
  logic [3:0] p1_q;
  logic [3:0] p2_q;
  logic       serve_dir_q;
  logic       ball_run_q;
  logic       ball_reset_q;
  logic       winner_q;
  logic       game_over_q;

  logic       pause_req;
  logic       paused;
  logic       running;

`ifdef PONG_MATCH_PAUSE_EN
  logic paused_q;

  assign pause_req  = bus.pause && (phase_q == SERVE || phase_q == PLAY);
  assign paused     = paused_q;
  assign bus.paused = paused_q;

  // Only POINT leads to OVER, so clearing there covers entry to OVER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paused_q <= 1'b0;
    end else if (pause_req) begin
      paused_q <= ~paused_q;
    end else if (phase_q == POINT) begin
      paused_q <= 1'b0;
    end
  end
`else
  assign pause_req = 1'b0;
  assign paused    = 1'b0;
`endif

  // A pause pulse cycle only toggles the flag; no game event is taken then.
  assign running = !pause_req && !paused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= IDLE;
      cnt_q        <= 8'd0;
      speed_q      <= 7'(INIT_SPEED);
      p1_q         <= 4'd0;
      p2_q         <= 4'd0;
      serve_dir_q  <= 1'b1;
      ball_run_q   <= 1'b0;
      ball_reset_q <= 1'b0;
      winner_q     <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      ball_reset_q <= 1'b0;
      case (phase_q)
        IDLE, OVER: begin
          if (bus.start) begin
            phase_q      <= SERVE;
            cnt_q        <= 8'(SERVE_TICKS);
            speed_q      <= 7'(INIT_SPEED);
            p1_q         <= 4'd0;
            p2_q         <= 4'd0;
            serve_dir_q  <= 1'b1;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b1;
            winner_q     <= 1'b0;
            game_over_q  <= 1'b0;
          end
        end
        SERVE: begin
          if (running && bus.tick) begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              phase_q    <= PLAY;
              ball_run_q <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (running) begin
            if (bus.goal_left) begin
              p2_q         <= p2_q + 4'd1;
              serve_dir_q  <= 1'b0;
              phase_q      <= POINT;
              ball_run_q   <= 1'b0;
              ball_reset_q <= 1'b1;
            end else if (bus.goal_right) begin
              p1_q         <= p1_q + 4'd1;
              serve_dir_q  <= 1'b1;
              phase_q      <= POINT;
              ball_run_q   <= 1'b0;
              ball_reset_q <= 1'b1;
            end else if (bus.paddle_hit && speed_q < 7'(MAX_SPEED)) begin
              speed_q <= speed_q + 7'd1;
            end
          end
        end
        POINT: begin
          if (p1_q == 4'(WIN_SCORE) || p2_q == 4'(WIN_SCORE)) begin
            phase_q     <= OVER;
            game_over_q <= 1'b1;
            winner_q    <= (p2_q == 4'(WIN_SCORE));
          end else begin
            phase_q <= SERVE;
            speed_q <= 7'(INIT_SPEED);
            cnt_q   <= 8'(SERVE_TICKS);
          end
        end
        default: phase_q <= IDLE;
      endcase
      // Pausing in PLAY stops the ball; un-pausing restarts it.
      if (pause_req) begin
        ball_run_q <= (phase_q == PLAY) && paused;
      end
    end
  end

  assign bus.ball_run   = ball_run_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.serve_dir  = serve_dir_q;
  assign bus.speed      = speed_q;
  assign bus.p1_score   = p1_q;
  assign bus.p2_score   = p2_q;
  assign bus.phase      = phase_q;
  assign bus.winner     = winner_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed match scenarios plus random play
// compared every cycle against a rule-level match model.
module tb_pong_match_ctrl;
  localparam int WIN = 3;
  localparam int ST  = 4;
  localparam int INI = 2;
  localparam int MAX = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  pong_match_ctrl_if bus();

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .SERVE_TICKS(ST), .INIT_SPEED(INI), .MAX_SPEED(MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Match model: phase numbers follow the published phase codes.
  int m_phase, m_left, m_p1, m_p2, m_speed;
  bit m_dir, m_run, m_rst, m_win, m_over, m_paused;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_p1 = 0; m_p2 = 0; m_speed = INI;
    m_dir = 1; m_run = 0; m_rst = 0; m_win = 0; m_over = 0; m_paused = 0;
  endtask

  task automatic model_step();
    bit pz;
    pz = 1'b0;
`ifdef PONG_MATCH_PAUSE_EN
    pz = bus.pause;
`endif
    m_rst = 0;
    if (m_phase == 0 || m_phase == 4) begin
      if (bus.start) begin
        m_phase = 1; m_left = ST; m_p1 = 0; m_p2 = 0; m_speed = INI;
        m_dir = 1; m_rst = 1; m_run = 0; m_over = 0; m_win = 0; m_paused = 0;
      end
    end else if (m_phase == 1) begin
      if (pz) m_paused = !m_paused;
      else if (!m_paused && bus.tick) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_phase = 2; m_run = 1; end
      end
    end else if (m_phase == 2) begin
      if (pz) begin
        m_paused = !m_paused;
        m_run = !m_paused;
      end else if (!m_paused) begin
        if (bus.goal_left || bus.goal_right) begin
          if (bus.goal_left) begin m_p2++; m_dir = 0; end
          else begin m_p1++; m_dir = 1; end
          m_phase = 3; m_run = 0; m_rst = 1;
        end else if (bus.paddle_hit) begin
          m_speed = (m_speed + 1 > MAX) ? MAX : m_speed + 1;
        end
      end
    end else if (m_phase == 3) begin
      m_paused = 0;
      if (m_p1 == WIN || m_p2 == WIN) begin
        m_phase = 4; m_over = 1; m_win = (m_p2 == WIN);
      end else begin
        m_phase = 1; m_speed = INI; m_left = ST;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("phase",      int'(bus.phase),      m_phase);
      chk("ball_run",   int'(bus.ball_run),   int'(m_run));
      chk("ball_reset", int'(bus.ball_reset), int'(m_rst));
      chk("serve_dir",  int'(bus.serve_dir),  int'(m_dir));
      chk("speed",      int'(bus.speed),      m_speed);
      chk("p1_score",   int'(bus.p1_score),   m_p1);
      chk("p2_score",   int'(bus.p2_score),   m_p2);
      chk("game_over",  int'(bus.game_over),  int'(m_over));
      if (m_over) chk("winner", int'(bus.winner), int'(m_win));
`ifdef PONG_MATCH_PAUSE_EN
      chk("paused",     int'(bus.paused),     int'(m_paused));
`endif
    end
  end

  task automatic step(input bit t, input bit s, input bit gl, input bit gr, input bit ph);
    bus.tick = t; bus.start = s; bus.goal_left = gl; bus.goal_right = gr; bus.paddle_hit = ph;
    @(posedge clk);
    #1;
    bus.tick = 0; bus.start = 0; bus.goal_left = 0; bus.goal_right = 0; bus.paddle_hit = 0;
  endtask

  task automatic serve();
    for (int i = 0; i < ST; i++) step(1, 0, 0, 0, 0);
  endtask

`ifdef PONG_MATCH_PAUSE_EN
  task automatic pause_step();
    bus.pause = 1'b1;
    step(0, 0, 0, 0, 0);
    bus.pause = 1'b0;
  endtask
`endif

  initial begin
    bus.tick = 0; bus.start = 0; bus.goal_left = 0; bus.goal_right = 0; bus.paddle_hit = 0;
`ifdef PONG_MATCH_PAUSE_EN
    bus.pause = 0;
`endif
    #1 rst_n = 1'b0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_speed", int'(bus.speed), 2);
    chk("rst_dir",   int'(bus.serve_dir), 1);
    chk("rst_run",   int'(bus.ball_run), 0);

    // Serve timing
    step(0, 1, 0, 0, 0);
    chk("start_phase", int'(bus.phase), 1);
    chk("start_breset", int'(bus.ball_reset), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      chk("serve_run_low", int'(bus.ball_run), 0);
    end
    step(0, 0, 0, 0, 0);
    chk("serve_hold", int'(bus.phase), 1);
    step(1, 0, 0, 0, 0);
    chk("play_phase", int'(bus.phase), 2);
    chk("play_run", int'(bus.ball_run), 1);

    // Speed saturation
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
    chk("speed_sat", int'(bus.speed), 15);

    // P1 scores
    step(0, 0, 0, 1, 0);
    chk("gr_phase", int'(bus.phase), 3);
    chk("gr_p1", int'(bus.p1_score), 1);
    chk("gr_breset", int'(bus.ball_reset), 1);
    step(0, 0, 0, 0, 0);
    chk("gr_serve", int'(bus.phase), 1);
    chk("gr_speed", int'(bus.speed), 2);

    // Simultaneous goals plus paddle
    serve();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 1);
    chk("sim_p2", int'(bus.p2_score), 1);
    chk("sim_p1", int'(bus.p1_score), 1);
    chk("sim_speed", int'(bus.speed), 5);
    chk("sim_dir", int'(bus.serve_dir), 0);
    step(0, 0, 0, 0, 0);

    // Match end for P2
    serve(); step(0, 0, 1, 0, 0); step(0, 0, 0, 0, 0);
    serve(); step(0, 0, 1, 0, 0); step(0, 0, 0, 0, 0);
    chk("over_phase", int'(bus.phase), 4);
    chk("over_flag", int'(bus.game_over), 1);
    chk("over_winner", int'(bus.winner), 1);
    step(1, 0, 1, 1, 1);
    chk("over_frozen", int'(bus.p2_score), 3);
    step(0, 1, 0, 0, 0);
    chk("restart_phase", int'(bus.phase), 1);
    chk("restart_p2", int'(bus.p2_score), 0);

    // Reset mid-PLAY
    serve();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
    serve(); step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
    serve();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    chk("pre_rst_p1", int'(bus.p1_score), 2);
    chk("pre_rst_speed", int'(bus.speed), 7);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_phase", int'(bus.phase), 0);
    chk("mid_rst_p1", int'(bus.p1_score), 0);
    chk("mid_rst_speed", int'(bus.speed), 2);
    chk("mid_rst_run", int'(bus.ball_run), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

`ifdef PONG_MATCH_PAUSE_EN
    step(0, 1, 0, 0, 0);
    serve();
    pause_step();
    chk("pause_run", int'(bus.ball_run), 0);
    step(0, 0, 0, 1, 0);
    chk("pause_goal_ign", int'(bus.p1_score), 0);
    pause_step();
    chk("resume_run", int'(bus.ball_run), 1);
`endif

    // Random play
    for (int c = 0; c < 4000; c++) begin
`ifdef PONG_MATCH_PAUSE_EN
      bus.pause = ($urandom_range(0, 24) == 0);
`endif
      step(1'($urandom_range(0, 1)),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 4) == 0);
    end
`ifdef PONG_MATCH_PAUSE_EN
    bus.pause = 0;
`endif
    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match-level sequencer for the pong datapath. Decides when the ball may move, when it is re-centred, who serves, the current ball speed, both scores, and when the match ends. Sits between the collision/goal detection logic and the ball-motion and score-display blocks. Runs on the game tick, not the pixel clock.

Parameters:
WIN_SCORE, 9, points needed to win; legal range 1..15.
SERVE_TICKS, 60, number of game ticks to hold the ball before a serve; legal range 1..255.
INIT_SPEED, 2, ball speed loaded at match start and after every point; 7-bit value.
MAX_SPEED, 15, speed saturation limit; must be >= INIT_SPEED and <= 127.

Ports:
clk  in  1  game-logic clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle game-tick strobe; all countdowns advance only on tick
start  in  1  one-cycle start-match pulse
goal_left  in  1  pulse: ball passed the left goal, so P2 scores
goal_right  in  1  pulse: ball passed the right goal, so P1 scores
paddle_hit  in  1  pulse: ball struck either paddle
ball_run  out  1  level; enables ball position updates
ball_reset  out  1  one-cycle pulse; ball-motion block re-centres the ball
serve_dir  out  1  1 = serve toward the right, 0 = toward the left
speed  out  7  current ball X/Y speed
p1_score  out  4  P1 score
p2_score  out  4  P2 score
phase  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
winner  out  1  0 = P1, 1 = P2; valid only while game_over=1
game_over  out  1  high in OVER

Behaviour:
- Reset (async assert, sync release):
  - phase IDLE.
  - ball_run=0, ball_reset=0.
  - serve_dir=1.
  - speed=INIT_SPEED.
  - both scores 0, winner=0, game_over=0.
  - serve counter 0.
- All outputs are registered.
- IDLE:
  - ball_run=0.
  - start -> SERVE in the next cycle. On that transition: clear scores, speed=INIT_SPEED, serve_dir=1, pulse ball_reset for 1 cycle, load counter=SERVE_TICKS.
- SERVE:
  - ball_run=0.
  - On each tick the counter decrements.
  - A tick while counter==1 moves to PLAY next cycle, with ball_run=1 from that cycle onward.
  - With no tick, the counter holds.
- PLAY:
  - ball_run=1.
  - paddle_hit: speed+1, saturating at MAX_SPEED.
  - goal_right: p1_score+1, serve_dir=1 -> POINT.
  - goal_left: p2_score+1, serve_dir=0 -> POINT.
  - On entry to POINT: ball_run=0 and ball_reset pulses 1 cycle, both in the same cycle as the transition.
  - goal_left and goal_right in the same cycle: goal_left wins and goal_right is dropped.
  - A goal in the same cycle as paddle_hit: the goal wins and speed is unchanged.
- POINT (exactly 1 cycle):
  - If the updated score equals WIN_SCORE -> OVER, with winner set to the scorer and game_over=1.
  - Otherwise -> SERVE, with speed=INIT_SPEED and counter=SERVE_TICKS.
- OVER:
  - ball_run=0, game_over=1, scores frozen.
  - start behaves exactly as in IDLE (new match).
- Ignored inputs:
  - start is ignored in SERVE, PLAY and POINT.
  - goal_left, goal_right and paddle_hit are ignored outside PLAY.
- Width: scores are 4-bit and never wrap, because the match ends at WIN_SCORE <= 15.
- Reset asserted mid-match returns to the reset state immediately; no partial score is retained.

Optional Feature:
- Macro: PONG_MATCH_PAUSE_EN
- Defined:
  - Adds input port pause (1 bit, one-cycle pulse).
  - pause toggles an internal paused flag, only in SERVE or PLAY.
  - While paused: ball_run=0, serve counter frozen, tick/goal/paddle_hit ignored, state held.
  - paused clears on reset and on entry to IDLE or OVER.
  - Additional output paused (1 bit).
- Not defined:
  - No pause or paused ports; paused is constant 0.
  - Behaviour is identical to the above with no pause.

Test Plan:
- Serve timing (WIN_SCORE=3, SERVE_TICKS=4, INIT_SPEED=2): start -> ball_reset pulses once, phase=1; after 4 ticks phase=2 and ball_run=1; before the 4th tick ball_run stays 0.
- Speed: in PLAY, 20 paddle_hit pulses with MAX_SPEED=15 -> speed steps 2,3,...,15 and holds 15; after any goal, speed=2 on re-entry to SERVE.
- Scoring: goal_right -> p1_score=1, serve_dir=1, phase 3 then 1, ball_reset one pulse; goal_left -> p2_score=1, serve_dir=0.
- Simultaneous events: goal_left + goal_right + paddle_hit in one cycle -> p2_score+1 only, p1_score unchanged, speed unchanged.
- Match end: three goal_left pulses -> phase=4, game_over=1, winner=1, p2_score=3; further goals are ignored; start -> scores 0, phase=1.
- Reset mid-PLAY with p1_score=2 and speed=7: assert reset -> immediately phase=0, scores 0, speed=2, ball_run=0. With PONG_MATCH_PAUSE_EN: pause in PLAY -> ball_run=0 and goals ignored; a second pause resumes.
